// File: rtl/rx_symbol_framer.sv
// ---------------------------------------------------------------------------
// rx_symbol_framer
//
// Front end of the 16-QAM receive chain. Raw 4-bit I/Q symbols from the
// sampler are searched for a run of PRE_LEN preamble symbols (PRE_I, PRE_Q).
// Once the run is found, the next N accepted symbols are a payload frame.
// Each payload symbol is registered to the demodulator outputs together with
// its deinterleaver write address alpha = (k*STEP + OFFSET) mod N. After the
// last payload symbol the input is held off for GUARD cycles so the
// deinterleaver and decoder can drain, and then the preamble hunt resumes.
//
// Optional feature, macro FRAMER_TIMEOUT_EN:
//   defined   - a PAYLOAD idle-cycle counter aborts the frame after TIMEOUT
//               cycles without an accept, pulses sync_lost and returns to
//               the hunt without a guard interval and without counting the
//               frame.
//   undefined - no counter is built, PAYLOAD waits indefinitely and
//               sync_lost is constant 0.
//
// Handshake: a symbol is transferred on a rising edge of clk where
//   in_valid && in_ready. in_ready is a decode of the registered state only
//   (never of in_valid), so the source may hold or drop in_valid freely.
//   sym_valid is a one-cycle qualifier for i_out/q_out/alpha_out with no
//   back-pressure from the demodulator.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   in_valid    in   input symbol present
//   in_i        in   [3:0] raw I symbol
//   in_q        in   [3:0] raw Q symbol
//   in_ready    out  framer accepts a symbol this cycle (0 during guard)
//   i_out       out  [3:0] registered payload I symbol
//   q_out       out  [3:0] registered payload Q symbol
//   alpha_out   out  [7:0] deinterleaver address, log2(N) bits zero-extended
//   sym_valid   out  i_out/q_out/alpha_out valid this cycle
//   frame_start out  pulse with payload symbol 0
//   frame_end   out  pulse with payload symbol N-1
//   sync_lost   out  one-cycle pulse on a timeout abort
//   frame_cnt   out  [15:0] completed frames, wraps
//
// Debug: the internal enum signal 'state' carries the FSM state
//   (ST_HUNT / ST_PAYLOAD / ST_GUARD) for checkers bound into this module.
// ---------------------------------------------------------------------------
module rx_symbol_framer #(
  parameter int         N       = 128,
  parameter int         PRE_LEN = 4,
  parameter logic [3:0] PRE_I   = 4'h7,
  parameter logic [3:0] PRE_Q   = 4'h9,
  parameter int         STEP    = 5,
  parameter int         OFFSET  = 3,
  parameter int         GUARD   = 16,
  parameter int         TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [3:0]  in_i,
  input  logic [3:0]  in_q,
  output logic        in_ready,
  output logic [3:0]  i_out,
  output logic [3:0]  q_out,
  output logic [7:0]  alpha_out,
  output logic        sym_valid,
  output logic        frame_start,
  output logic        frame_end,
  output logic        sync_lost,
  output logic [15:0] frame_cnt
);

  // ------------------------------------------------------------------------
  // Parameter sanity (elaboration time only)
  // ------------------------------------------------------------------------
  if (N < 2 || N > 256 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("rx_symbol_framer: N must be a power of 2 in 2..256");
  end
  if (PRE_LEN < 1 || PRE_LEN > 15) begin : g_bad_pre_len
    $error("rx_symbol_framer: PRE_LEN must be in 1..15");
  end
  if ((STEP % 2) == 0) begin : g_bad_step
    $error("rx_symbol_framer: STEP must be odd");
  end
  if (OFFSET < 0 || OFFSET >= N) begin : g_bad_offset
    $error("rx_symbol_framer: OFFSET must be in 0..N-1");
  end
  if (GUARD < 1 || GUARD > 65536) begin : g_bad_guard
    $error("rx_symbol_framer: GUARD must be in 1..65536");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65536) begin : g_bad_timeout
    $error("rx_symbol_framer: TIMEOUT must be in 1..65536");
  end

  // ------------------------------------------------------------------------
  // Constants
  // ------------------------------------------------------------------------
  localparam int AW = $clog2(N);

  // alpha is exactly log2(N) bits wide, so the natural wrap of an AW-bit
  // adder is the "mod N" of the address recurrence.
  localparam logic [AW-1:0] ALPHA0    = AW'(OFFSET);
  localparam logic [AW-1:0] STEP_W    = AW'(STEP);
  localparam logic [7:0]    K_LAST    = 8'(N - 1);
  localparam logic [3:0]    PCNT_LAST = 4'(PRE_LEN - 1);
  localparam logic [15:0]   GCNT_INIT = 16'(GUARD - 1);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_GUARD   = 2'd2
  } state_t;

  // ------------------------------------------------------------------------
  // Registered state and counters
  // ------------------------------------------------------------------------
  state_t        state;
  state_t        state_n;
  logic [3:0]    pcnt;      // consecutive preamble symbols seen in HUNT
  logic [3:0]    pcnt_n;
  logic [7:0]    k;         // payload symbol index within the frame
  logic [7:0]    k_n;
  logic [AW-1:0] alpha;     // address for the next payload symbol
  logic [AW-1:0] alpha_n;
  logic [15:0]   gcnt;      // guard cycles still to run, minus one
  logic [15:0]   gcnt_n;

  logic accept;
  logic pre_match;
  logic timeout_hit;

  // Registered-output next values
  logic        sym_valid_n;
  logic        frame_start_n;
  logic        frame_end_n;
  logic        sync_lost_n;
  logic [3:0]  i_out_n;
  logic [3:0]  q_out_n;
  logic [7:0]  alpha_out_n;
  logic [15:0] frame_cnt_n;

  assign accept    = in_valid && in_ready;
  assign pre_match = (in_i == PRE_I) && (in_q == PRE_Q);

  // ------------------------------------------------------------------------
  // PAYLOAD idle-cycle watchdog
  // ------------------------------------------------------------------------
`ifdef FRAMER_TIMEOUT_EN
  localparam logic [15:0] TCNT_LAST = 16'(TIMEOUT - 1);

  logic [15:0] tcnt;        // idle cycles since the last PAYLOAD accept
  logic [15:0] tcnt_n;

  // The abort fires on the TIMEOUT-th consecutive idle edge in PAYLOAD;
  // because it needs !accept it can never coincide with the frame_end
  // accept, so sync_lost and frame_end are mutually exclusive.
  assign timeout_hit = (state == ST_PAYLOAD) && !accept && (tcnt == TCNT_LAST);

  always_comb begin
    tcnt_n = 16'd0;
    if (state == ST_PAYLOAD && !accept && !timeout_hit) begin
      tcnt_n = tcnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= 16'd0;
    end else begin
      tcnt <= tcnt_n;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // ------------------------------------------------------------------------
  // FSM process 1: state register (plus the counters it owns)
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_HUNT;
      pcnt  <= 4'd0;
      k     <= 8'd0;
      alpha <= ALPHA0;
      gcnt  <= 16'd0;
    end else begin
      state <= state_n;
      pcnt  <= pcnt_n;
      k     <= k_n;
      alpha <= alpha_n;
      gcnt  <= gcnt_n;
    end
  end

  // ------------------------------------------------------------------------
  // FSM process 2: next state and counter updates
  // ------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    k_n     = k;
    alpha_n = alpha;
    gcnt_n  = gcnt;

    unique case (state)
      ST_HUNT: begin
        // Idle cycles leave pcnt alone; any non-matching symbol restarts.
        if (accept) begin
          if (!pre_match) begin
            pcnt_n = 4'd0;
          end else if (pcnt == PCNT_LAST) begin
            state_n = ST_PAYLOAD;
            pcnt_n  = 4'd0;
            k_n     = 8'd0;
            alpha_n = ALPHA0;
          end else begin
            pcnt_n = pcnt + 4'd1;
          end
        end
      end

      ST_PAYLOAD: begin
        if (accept) begin
          k_n     = k + 8'd1;
          alpha_n = alpha + STEP_W;
          if (k == K_LAST) begin
            state_n = ST_GUARD;
            gcnt_n  = GCNT_INIT;
            k_n     = 8'd0;
            alpha_n = ALPHA0;
          end
        end else if (timeout_hit) begin
          state_n = ST_HUNT;
          pcnt_n  = 4'd0;
          k_n     = 8'd0;
          alpha_n = ALPHA0;
        end
      end

      ST_GUARD: begin
        // GUARD-1 down to 0 inclusive gives exactly GUARD cycles here.
        if (gcnt == 16'd0) begin
          state_n = ST_HUNT;
          pcnt_n  = 4'd0;
        end else begin
          gcnt_n = gcnt - 16'd1;
        end
      end

      default: begin
        state_n = ST_HUNT;
        pcnt_n  = 4'd0;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // FSM process 3: outputs (in_ready decode and next registered outputs)
  // ------------------------------------------------------------------------
  always_comb begin
    in_ready      = (state != ST_GUARD);

    sym_valid_n   = 1'b0;
    frame_start_n = 1'b0;
    frame_end_n   = 1'b0;
    sync_lost_n   = timeout_hit;
    i_out_n       = i_out;
    q_out_n       = q_out;
    alpha_out_n   = alpha_out;
    frame_cnt_n   = frame_cnt;

    // in_ready is 1 in PAYLOAD, so accept here is simply in_valid.
    if (state == ST_PAYLOAD && accept) begin
      sym_valid_n   = 1'b1;
      frame_start_n = (k == 8'd0);
      frame_end_n   = (k == K_LAST);
      i_out_n       = in_i;
      q_out_n       = in_q;
      alpha_out_n   = 8'(alpha);
      if (k == K_LAST) begin
        frame_cnt_n = frame_cnt + 16'd1;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Output registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      i_out       <= 4'd0;
      q_out       <= 4'd0;
      alpha_out   <= 8'd0;
      frame_cnt   <= 16'd0;
    end else begin
      sym_valid   <= sym_valid_n;
      frame_start <= frame_start_n;
      frame_end   <= frame_end_n;
      i_out       <= i_out_n;
      q_out       <= q_out_n;
      alpha_out   <= alpha_out_n;
      frame_cnt   <= frame_cnt_n;
    end
  end

`ifdef FRAMER_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_lost <= 1'b0;
    end else begin
      sync_lost <= sync_lost_n;
    end
  end
`else
  // Without the watchdog timeout_hit is constant 0; keep the net tied off.
  logic unused_sync;
  assign unused_sync = sync_lost_n;
  assign sync_lost   = unused_sync;
`endif

endmodule

// File: tb/tb_rx_symbol_framer.sv
// ---------------------------------------------------------------------------
// tb_rx_symbol_framer
//
// Self-checking bench for rx_symbol_framer with default parameters.
// Drivers issue symbols and push the expected demodulator word
// {frame_start, frame_end, alpha, i, q} into exp_q at the accepting edge; an
// independent monitor pops and compares at every falling edge. Expected
// values come from the frame rules: lock position by a sliding-window scan
// of the offered symbols, alpha from (k*STEP+OFFSET) mod N, guard length
// from GUARD.
// ---------------------------------------------------------------------------
module tb_rx_symbol_framer;

  localparam int         N       = 128;
  localparam int         PRE_LEN = 4;
  localparam logic [3:0] PRE_I   = 4'h7;
  localparam logic [3:0] PRE_Q   = 4'h9;
  localparam int         STEP    = 5;
  localparam int         OFFSET  = 3;
  localparam int         GUARD   = 16;
  localparam int         TIMEOUT = 64;

  // ------------------------------------------------------------------------
  // Clock / reset / DUT
  // ------------------------------------------------------------------------
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_i;
  logic [3:0]  in_q;
  logic        in_ready;
  logic [3:0]  i_out;
  logic [3:0]  q_out;
  logic [7:0]  alpha_out;
  logic        sym_valid;
  logic        frame_start;
  logic        frame_end;
  logic        sync_lost;
  logic [15:0] frame_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rx_symbol_framer #(
    .N(N), .PRE_LEN(PRE_LEN), .PRE_I(PRE_I), .PRE_Q(PRE_Q),
    .STEP(STEP), .OFFSET(OFFSET), .GUARD(GUARD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_i(in_i),
    .in_q(in_q),
    .in_ready(in_ready),
    .i_out(i_out),
    .q_out(q_out),
    .alpha_out(alpha_out),
    .sym_valid(sym_valid),
    .frame_start(frame_start),
    .frame_end(frame_end),
    .sync_lost(sync_lost),
    .frame_cnt(frame_cnt)
  );

  // ------------------------------------------------------------------------
  // Scoreboard state
  // ------------------------------------------------------------------------
  int          tests_run = 0;
  int          failures  = 0;
  logic [17:0] exp_q[$];
  logic [7:0]  hunt_q[$];
  int          alpha_seen[N];
  int          exp_frame_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] exp_word(input int k, input logic [3:0] i, input logic [3:0] q);
    logic [7:0] a;
    a = 8'((k * STEP + OFFSET) % N);
    return {(k == 0), (k == N - 1), a, i, q};
  endfunction

  // ------------------------------------------------------------------------
  // Monitor: every sym_valid cycle consumes exactly one expected word, and
  // every expected word must appear on the falling edge right after the
  // accepting edge (one-cycle latency).
  // ------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst) begin
      if (sym_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sym_valid", 32'(sym_valid), 32'd0);
        end else begin
          check("sym_out", 32'({frame_start, frame_end, alpha_out, i_out, q_out}),
                32'(exp_q.pop_front()));
          if (alpha_out < 8'(N)) alpha_seen[alpha_out]++;
        end
      end else if (exp_q.size() != 0) begin
        check("missing_sym_valid", 32'(sym_valid), 32'd1);
        void'(exp_q.pop_front());
      end
      if (sync_lost && frame_end) begin
        check("sync_lost_with_frame_end", 32'd1, 32'd0);
      end
    end
  end

  // ------------------------------------------------------------------------
  // Driver tasks
  // ------------------------------------------------------------------------
  // One clock: present inputs on the falling edge, check in_ready, and push
  // the expected word just after the rising edge that accepts it.
  task automatic step(input bit v, input logic [3:0] i, input logic [3:0] q,
                      input bit exp_ready, input bit push, input logic [17:0] e);
    @(negedge clk);
    in_valid = v;
    in_i     = i;
    in_q     = q;
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    @(posedge clk);
    #1;
    if (push) exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1, 1'b0, 18'd0);
  endtask

  // Offer hunt_q until the first position whose trailing PRE_LEN symbols are
  // all preamble; nothing may be forwarded while hunting.
  task automatic do_hunt(input bit gaps);
    int lock;
    bit all;
    lock = -1;
    for (int j = PRE_LEN - 1; j < hunt_q.size() && lock < 0; j++) begin
      all = 1'b1;
      for (int t = j - PRE_LEN + 1; t <= j; t++) begin
        if (hunt_q[t] != {PRE_I, PRE_Q}) all = 1'b0;
      end
      if (all) lock = j;
    end
    for (int j = 0; j <= lock; j++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle();
      step(1'b1, hunt_q[j][7:4], hunt_q[j][3:0], 1'b1, 1'b0, 18'd0);
    end
  endtask

  task automatic random_hunt();
    int len;
    hunt_q.delete();
    len = $urandom_range(0, 12);
    for (int j = 0; j < len; j++) begin
      if ($urandom_range(0, 3) != 0) hunt_q.push_back({PRE_I, PRE_Q});
      else hunt_q.push_back(8'($urandom_range(0, 255)));
    end
    for (int j = 0; j < PRE_LEN; j++) hunt_q.push_back({PRE_I, PRE_Q});
    do_hunt(1'b1);
  endtask

  task automatic clean_hunt();
    hunt_q.delete();
    for (int j = 0; j < PRE_LEN; j++) hunt_q.push_back({PRE_I, PRE_Q});
    do_hunt(1'b0);
  endtask

  // gap_mode: 0 back-to-back, 1 idle before every symbol, 2 random 0..3 idles
  task automatic payload(input int k_first, input int k_last, input int gap_mode);
    logic [3:0] i;
    logic [3:0] q;
    int g;
    for (int k = k_first; k <= k_last; k++) begin
      g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      for (int n = 0; n < g; n++) idle();
      i = 4'($urandom_range(0, 15));
      q = 4'($urandom_range(0, 15));
      step(1'b1, i, q, 1'b1, 1'b1, exp_word(k, i, q));
    end
  endtask

  // Exactly GUARD cycles of in_ready low while a preamble is offered, then
  // the hunt's own in_ready checks confirm the framer reopens.
  task automatic guard_and_count();
    exp_frame_cnt++;
    for (int g = 0; g < GUARD; g++) step(1'b1, PRE_I, PRE_Q, 1'b0, 1'b0, 18'd0);
    check("frame_cnt", 32'(frame_cnt), 32'(exp_frame_cnt));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sym_valid"}, 32'(sym_valid), 32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check({tag, "_frame_end"}, 32'(frame_end), 32'd0);
    check({tag, "_sync_lost"}, 32'(sync_lost), 32'd0);
    check({tag, "_iq_alpha"}, 32'({i_out, q_out, alpha_out}), 32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  // ------------------------------------------------------------------------
  // Watchdog
  // ------------------------------------------------------------------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, failures + 1);
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------------
  initial begin
    int bad;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_i     = 4'd0;
    in_q     = 4'd0;

    // Reset is applied before the first edge: outputs must already be 0.
    #2;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Nominal frame: clean preamble, 128 back-to-back payload symbols.
    foreach (alpha_seen[a]) alpha_seen[a] = 0;
    clean_hunt();
    payload(0, N - 1, 0);
    guard_and_count();
    bad = 0;
    foreach (alpha_seen[a]) if (alpha_seen[a] != 1) bad++;
    check("alpha_bijection", 32'(bad), 32'd0);

    // Broken preamble: lock only after the eighth symbol; gapped payload.
    hunt_q.delete();
    for (int j = 0; j < 3; j++) hunt_q.push_back({PRE_I, PRE_Q});
    hunt_q.push_back({PRE_I, 4'h8});
    for (int j = 0; j < 4; j++) hunt_q.push_back({PRE_I, PRE_Q});
    do_hunt(1'b0);
    payload(0, N - 1, 1);
    guard_and_count();

    // Randomized frames.
    for (int f = 0; f < 3; f++) begin
      random_hunt();
      payload(0, N - 1, 2);
      guard_and_count();
    end

`ifdef FRAMER_TIMEOUT_EN
    // Stall after payload symbol 50: abort on the TIMEOUT-th idle edge.
    clean_hunt();
    payload(0, 50, 0);
    for (int s = 1; s <= TIMEOUT + 2; s++) begin
      idle();
      check("sync_lost_pulse", 32'(sync_lost), 32'(s == TIMEOUT));
    end
    check("frame_cnt_after_abort", 32'(frame_cnt), 32'(exp_frame_cnt));
    random_hunt();
    payload(0, N - 1, 0);
    guard_and_count();
`else
    // Without the watchdog a long stall just pauses the frame.
    clean_hunt();
    payload(0, 50, 0);
    for (int s = 1; s <= TIMEOUT + 6; s++) begin
      idle();
      check("no_sync_lost", 32'(sync_lost), 32'd0);
    end
    payload(51, N - 1, 0);
    guard_and_count();
`endif

    // Reset mid-payload, between clock edges.
    clean_hunt();
    payload(0, 69, 0);
    #2;
    rst = 1'b1;
    exp_q.delete();
    exp_frame_cnt = 0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    clean_hunt();
    payload(0, N - 1, 2);
    guard_and_count();

    repeat (3) idle();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/rx_symbol_framer.md
# rx_symbol_framer

Upstream front end of the 16-QAM receiver chain. It accepts raw 4-bit I/Q symbols from the sampler and hunts for a fixed preamble, then delimits a payload frame of N symbols. For each payload symbol it generates the deinterleaver write address `alpha`, and drives the demodulator's `sym_valid`/`i_in`/`q_in`/`alpha_sym` inputs. A guard interval between frames gives the deinterleaver and decoder time to drain.

## Interface
- `N`, 128: payload symbols per frame; power of 2, 2..256.
- `PRE_LEN`, 4: consecutive preamble symbols required for lock; 1..15.
- `PRE_I`, 4'h7: preamble I value.
- `PRE_Q`, 4'h9: preamble Q value.
- `STEP`, 5: interleave stride; must be odd.
- `OFFSET`, 3: alpha of payload symbol 0; less than N.
- `GUARD`, 16: cycles `in_ready` is held low after each frame; ≥1.
- `TIMEOUT`, 64: idle-cycle limit, used only with `FRAMER_TIMEOUT_EN`.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: input symbol present.
- `in_i`, in, 4: raw I symbol.
- `in_q`, in, 4: raw Q symbol.
- `in_ready`, out, 1: framer accepts a symbol this cycle.
- `i_out`, out, 4: registered payload I symbol.
- `q_out`, out, 4: registered payload Q symbol.
- `alpha_out`, out, 8: deinterleaver address; bits above log2(N) are 0.
- `sym_valid`, out, 1: `i_out`, `q_out` and `alpha_out` are valid this cycle.
- `frame_start`, out, 1: pulse coincident with payload symbol 0.
- `frame_end`, out, 1: pulse coincident with payload symbol N-1.
- `sync_lost`, out, 1: one-cycle pulse on a timeout abort.
- `frame_cnt`, out, 16: count of completed frames; wraps.

## Operation
- **Accept:** a symbol is accepted on a rising edge where `in_valid && in_ready`. `in_ready` is a combinational decode of the registered state: 1 in HUNT and PAYLOAD, 0 in GUARD. Gaps in `in_valid` are allowed in every state.
- **HUNT:**
  - `pcnt` counts consecutive accepted symbols with `in_i==PRE_I && in_q==PRE_Q`.
  - A non-matching accepted symbol clears `pcnt` to 0.
  - Idle cycles leave `pcnt` unchanged.
  - When a matching symbol makes `pcnt==PRE_LEN`, go to PAYLOAD with `k=0` and `alpha=OFFSET`.
  - Preamble symbols are never forwarded.
- **PAYLOAD:**
  - Each accepted symbol is registered to `i_out`/`q_out` with `alpha_out=alpha` and `sym_valid=1`.
  - Then `k<=k+1` and `alpha<=(alpha+STEP) mod N`.
  - Payload symbols that match the preamble are forwarded normally.
  - `frame_start` is set when k==0; `frame_end` is set when k==N-1.
  - On the accept where k==N-1: `frame_cnt` increments, then go to GUARD with `gcnt=GUARD-1`.
- **GUARD:** decrement `gcnt` every cycle; when `gcnt==0`, go to HUNT with `pcnt=0`.
- **Alpha:** because STEP is odd and N is a power of 2, alpha = (k·STEP+OFFSET) mod N is a bijection over the frame. Alpha uses log2(N) bits, zero-extended to 8 bits.
- **Reset values:**
  - State HUNT, `pcnt`/`k`/`gcnt`/timeout counter = 0.
  - `sym_valid`, `frame_start`, `frame_end`, `sync_lost` = 0.
  - `i_out`, `q_out`, `alpha_out` = 0; `frame_cnt` = 0.
- **Reset mid-frame:** asynchronous assertion forces all reset values immediately, and any partial frame is discarded. No `frame_end` is emitted for it and `frame_cnt` is unchanged from 0.

## Timing
- **Latency:** 1 cycle from the accepting edge to `sym_valid` high. `sym_valid`, `frame_start` and `frame_end` are single-cycle per accepted symbol.
- **Throughput:** one symbol per cycle in PAYLOAD.
- **Lock:** the PAYLOAD state is entered on the edge accepting preamble symbol PRE_LEN. The symbol accepted on the next valid cycle is payload 0.
- **Guard:** `in_ready` goes low the cycle after the last payload accept and stays low exactly GUARD cycles. Preamble hunting resumes on the following cycle.
- **Minimum frame period:** PRE_LEN + N + GUARD cycles.
- `sync_lost` and `frame_end` are never asserted in the same cycle.

## Configuration
- Macro: `FRAMER_TIMEOUT_EN`.
- **Defined:** in PAYLOAD, a counter increments on each cycle without an accept and clears on each accept.
  - When it reaches TIMEOUT, `sync_lost` pulses for one cycle.
  - The state returns to HUNT with `pcnt=0`, `k=0`, `alpha=OFFSET`, no GUARD interval, and `frame_cnt` unchanged.
  - No `frame_end` is emitted for the aborted frame.
- **Undefined:** no counter logic is built, PAYLOAD waits indefinitely, and `sync_lost` is tied to 0.

## Test plan
- **Reset:** assert `rst` asynchronously between edges → all outputs 0 immediately; `in_ready=1`; state HUNT.
- **Nominal frame (defaults):** 4 symbols (7,9), then 128 payload symbols back-to-back → 128 `sym_valid` pulses, each 1 cycle after its accept. Alpha sequence is 3, 8, 13, …, with the last value 126. Every value 0..127 appears exactly once. `frame_start` on the first pulse, `frame_end` on the last, `frame_cnt=1`.
- **Broken preamble:** 3×(7,9), then (7,8), then 4×(7,9) → lock only after the 8th symbol; no output before that.
- **Gapped payload and guard:** drop `in_valid` on every other cycle during payload → alpha ordering is unchanged. After `frame_end`, `in_ready=0` for exactly 16 cycles. A preamble offered during the guard is not accepted.
- **Timeout, macro defined:** stall 64 cycles after payload symbol 50 → one `sync_lost` pulse, no `frame_end`, `frame_cnt` unchanged. A fresh preamble then restarts the frame at alpha=3.
- **Reset mid-payload:** assert `rst` at symbol 70 → outputs cleared. A following full frame gives `frame_cnt=1` and starts at alpha=3.
